// File: rtl/timer_unit.sv
// -----------------------------------------------------------------------------
// timer_unit
//
// Programmable interval timer that serves the traffic-light FSM. The FSM
// selects an interval code and pulses start_timer. The timer counts that many
// seconds and returns a one-cycle expired pulse. Four user-programmable
// interval lengths (base, ext, yel, walk) are held here and are rewritten
// through the synchronized programming strobe. A free-running 1 Hz enable is
// also provided for other blocks.
//
// Ports:
//   clk            in   system clock
//   Reset          in   asynchronous, active-high reset
//   interval       in   [2:0] interval code: 0 base, 1 ext, 2 yel, 3 walk,
//                       4-7 reserved (count 1 second)
//   start_timer    in   one-cycle pulse: load and start (or restart) countdown
//   Prog_Sync      in   synchronized one-cycle programming strobe
//   Time_Param_Sel in   [1:0] parameter slot to program
//   Time_Value     in   [3:0] new value in seconds (0 restores the default)
//   expired        out  one-cycle pulse: selected interval elapsed
//   busy           out  countdown active
//   seconds_left   out  [3:0] remaining whole seconds, 0 when idle
//   one_hz_enable  out  one-cycle pulse every TICKS_PER_SEC cycles
//
// Handshake: start_timer and Prog_Sync are single-cycle strobes with no
// back-pressure; each is acted on at the rising clock edge where it is high.
// Prog_Sync has priority over start_timer. expired is a single-cycle
// strobe asserted in the cycle after the final countdown wrap.
// -----------------------------------------------------------------------------
module timer_unit #(
    parameter int         TICKS_PER_SEC = 100000000,
    parameter logic [3:0] T_BASE_DEF    = 4'd6,
    parameter logic [3:0] T_EXT_DEF     = 4'd3,
    parameter logic [3:0] T_YEL_DEF     = 4'd2,
    parameter logic [3:0] T_WALK_DEF    = 4'd3
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [2:0] interval,
    input  logic       start_timer,
    input  logic       Prog_Sync,
    input  logic [1:0] Time_Param_Sel,
    input  logic [3:0] Time_Value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] seconds_left,
    output logic       one_hz_enable
);

    localparam int            CW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(TICKS_PER_SEC - 1);
    localparam logic [CW-1:0] TICK_ONE = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_q, div_d;        // free-running 1 Hz divider
    logic          one_hz_q, one_hz_d;
    logic [CW-1:0] presc_q, presc_d;    // countdown prescaler, phase-aligned to start
    logic [3:0]    sec_q, sec_d;
    logic          expired_q, expired_d;
    logic          busy_q, busy_d;
    logic [3:0]    param_q [4];
    logic [3:0]    param_d [4];
    logic [3:0]    lookup;

    // Default seconds for each programmable slot.
    function automatic logic [3:0] def_of(input logic [1:0] sel);
        logic [3:0] v;
        case (sel)
            2'd0:    v = T_BASE_DEF;
            2'd1:    v = T_EXT_DEF;
            2'd2:    v = T_YEL_DEF;
            default: v = T_WALK_DEF;
        endcase
        return v;
    endfunction

    // Interval length for the code presented on the start cycle.
    always_comb begin
        case (interval)
            3'd0:    lookup = param_q[0];
            3'd1:    lookup = param_q[1];
            3'd2:    lookup = param_q[2];
            3'd3:    lookup = param_q[3];
            default: lookup = 4'd1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        sec_d     = sec_q;
        expired_d = 1'b0;
        busy_d    = busy_q;
        param_d   = param_q;

        // Divider runs regardless of the countdown.
        if (div_q == TICK_MAX) begin
            div_d    = '0;
            one_hz_d = 1'b1;
        end else begin
            div_d    = div_q + TICK_ONE;
            one_hz_d = 1'b0;
        end

        if (Prog_Sync) begin
            // A write always aborts any countdown silently.
            param_d[Time_Param_Sel] = (Time_Value == 4'd0) ? def_of(Time_Param_Sel)
                                                           : Time_Value;
            state_d = IDLE;
            presc_d = '0;
            sec_d   = 4'd0;
            busy_d  = 1'b0;
        end else if (start_timer) begin
            // A start landing on the final wrap still reports the finished count.
            expired_d = (state_q == COUNT) && (presc_q == TICK_MAX) && (sec_q == 4'd1);
            state_d   = COUNT;
            presc_d   = '0;
            sec_d     = lookup;
            busy_d    = 1'b1;
        end else if (state_q == COUNT) begin
            if (presc_q == TICK_MAX) begin
                presc_d = '0;
                if (sec_q <= 4'd1) begin
                    // Saturate at zero; only a real 1->0 transition reports expiry.
                    expired_d = (sec_q == 4'd1);
                    sec_d     = 4'd0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    sec_d = sec_q - 4'd1;
                end
            end else begin
                presc_d = presc_q + TICK_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            one_hz_q   <= 1'b0;
            presc_q    <= '0;
            sec_q      <= 4'd0;
            expired_q  <= 1'b0;
            busy_q     <= 1'b0;
            param_q[0] <= T_BASE_DEF;
            param_q[1] <= T_EXT_DEF;
            param_q[2] <= T_YEL_DEF;
            param_q[3] <= T_WALK_DEF;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            one_hz_q  <= one_hz_d;
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            expired_q <= expired_d;
            busy_q    <= busy_d;
            param_q   <= param_d;
        end
    end

    assign expired       = expired_q;
    assign busy          = busy_q;
    assign seconds_left  = sec_q;
    assign one_hz_enable = one_hz_q;

endmodule

// File: tb/tb_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_timer_unit
//
// Directed bench for timer_unit with TICKS_PER_SEC = 4. Expected expiry edges
// are pushed to exp_q when a start is driven and popped when the edge arrives.
// busy, seconds_left and one_hz_enable are checked against values derived
// from the cycle count since the start edge.
// -----------------------------------------------------------------------------
module tb_timer_unit;

    localparam int T = 4;

    logic       clk;
    logic       Reset;
    logic [2:0] interval;
    logic       start_timer;
    logic       Prog_Sync;
    logic [1:0] Time_Param_Sel;
    logic [3:0] Time_Value;
    logic       expired;
    logic       busy;
    logic [3:0] seconds_left;
    logic       one_hz_enable;

    timer_unit #(
        .TICKS_PER_SEC(T)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .interval      (interval),
        .start_timer   (start_timer),
        .Prog_Sync     (Prog_Sync),
        .Time_Param_Sel(Time_Param_Sel),
        .Time_Value    (Time_Value),
        .expired       (expired),
        .busy          (busy),
        .seconds_left  (seconds_left),
        .one_hz_enable (one_hz_enable)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];   // edge numbers at which expired must be seen
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc   = 0;
    int          hz_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        logic hz_exp;
        logic exp_now;
        @(posedge clk);
        #1;
        cyc++;
        if (Reset) begin
            hz_exp = 1'b0;
            hz_cnt = 0;
        end else begin
            hz_exp = (hz_cnt == T - 1);
            hz_cnt = hz_exp ? 0 : hz_cnt + 1;
        end
        exp_now = (exp_q.size() > 0) && (exp_q[0] == cyc);
        if (exp_now) void'(exp_q.pop_front());
        chk("one_hz_enable", {31'd0, one_hz_enable}, {31'd0, hz_exp});
        chk("expired", {31'd0, expired}, {31'd0, exp_now});
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic prog(input logic [1:0] sel, input logic [3:0] val);
        Prog_Sync      = 1'b1;
        Time_Param_Sel = sel;
        Time_Value     = val;
        step();
        Prog_Sync      = 1'b0;
    endtask

    // Drive a start with the bench's own knowledge of the interval length n.
    task automatic start_count(input logic [2:0] code, input int n);
        interval    = code;
        start_timer = 1'b1;
        exp_q.push_back(32'(cyc + 1 + n * T));
        step();
        start_timer = 1'b0;
        chk("busy_at_start", {31'd0, busy}, 32'd1);
        chk("secs_at_start", {28'd0, seconds_left}, 32'(n));
    endtask

    // k edges after a start of n seconds.
    task automatic follow(input int n, input int k);
        for (int j = 1; j <= k; j++) begin
            step();
            chk("busy", {31'd0, busy}, (j < n * T) ? 32'd1 : 32'd0);
            chk("seconds_left", {28'd0, seconds_left}, (j < n * T) ? 32'(n - j / T) : 32'd0);
        end
    endtask

    task automatic queue_drained(input string tag);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_count(input logic [2:0] code, input int n, input string tag);
        start_count(code, n);
        follow(n, n * T);
        idle(2);
        queue_drained(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        Reset          = 1'b0;
        interval       = 3'd0;
        start_timer    = 1'b0;
        Prog_Sync      = 1'b0;
        Time_Param_Sel = 2'd0;
        Time_Value     = 4'd0;
        #1 Reset = 1'b1;
        idle(2);
        chk("rst_expired", {31'd0, expired}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_secs", {28'd0, seconds_left}, 32'd0);
        chk("rst_one_hz", {31'd0, one_hz_enable}, 32'd0);
        Reset = 1'b0;
        idle(3);

        // Base green default: 6 s -> 24 cycles.
        run_count(3'd0, 6, "base_default_done");

        // Program yellow to 5 s, then back to default via value 0.
        prog(2'd2, 4'd5);
        run_count(3'd2, 5, "yel_5_done");
        prog(2'd2, 4'd0);
        run_count(3'd2, 2, "yel_default_done");

        // Restart: ext (3 s) restarted at +6 with yellow (2 s); expiry at +14 only.
        start_count(3'd1, 3);
        follow(3, 5);
        exp_q.delete();      // the aborted count must not report expiry
        start_count(3'd2, 2);
        follow(2, 10);
        queue_drained("restart_done");

        // Prog_Sync mid-count aborts silently and writes walk = 7.
        start_count(3'd3, 3);
        follow(3, 4);
        exp_q.delete();
        prog(2'd3, 4'd7);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_secs", {28'd0, seconds_left}, 32'd0);
        idle(14);
        run_count(3'd3, 7, "walk_7_done");

        // Prog_Sync together with start_timer: stays idle, base = 2.
        Prog_Sync      = 1'b1;
        start_timer    = 1'b1;
        Time_Param_Sel = 2'd0;
        Time_Value     = 4'd2;
        interval       = 3'd0;
        step();
        Prog_Sync   = 1'b0;
        start_timer = 1'b0;
        chk("both_busy", {31'd0, busy}, 32'd0);
        chk("both_secs", {28'd0, seconds_left}, 32'd0);
        idle(3);
        chk("both_idle_busy", {31'd0, busy}, 32'd0);
        run_count(3'd0, 2, "base_2_done");

        // Asynchronous reset mid-count clears outputs without a clock edge.
        start_count(3'd0, 2);
        follow(2, 6);
        #2 Reset = 1'b1;
        hz_cnt = 0;
        #1;
        chk("arst_expired", {31'd0, expired}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_secs", {28'd0, seconds_left}, 32'd0);
        chk("arst_one_hz", {31'd0, one_hz_enable}, 32'd0);
        exp_q.delete();
        step();
        Reset = 1'b0;
        idle(2);
        run_count(3'd5, 1, "reserved_code_done");
        run_count(3'd0, 6, "base_restored_done");
        run_count(3'd3, 3, "walk_restored_done");

        // Start coinciding with the final wrap: one expiry, count continues.
        start_count(3'd2, 2);
        follow(2, 7);
        start_count(3'd2, 2);
        follow(2, 8);
        idle(2);
        queue_drained("wrap_restart_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/timer_unit.md
Name: timer_unit

Overview:
- Programmable interval timer that sits directly beside the traffic-light FSM and serves it.
- Consumes the FSM's interval code and start_timer pulse. Counts the selected number of seconds and returns a one-cycle expired pulse.
- Holds the four user-programmable time parameters, which are rewritten through the synchronized programming strobe Prog_Sync.
- Also provides a 1 Hz enable for other blocks.

Parameters:
- TICKS_PER_SEC, 100000000: clock cycles per second. Set to 4 in simulation.
- T_BASE_DEF, 6: reset/default seconds for base green (code 0).
- T_EXT_DEF, 3: reset/default seconds for extended green (code 1).
- T_YEL_DEF, 2: reset/default seconds for yellow (code 2).
- T_WALK_DEF, 3: reset/default seconds for walk (code 3).

Ports:
- clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- interval  in  3  interval code from FSM: 0 base, 1 ext, 2 yel, 3 walk, 4-7 reserved
- start_timer  in  1  one-cycle pulse from FSM: load and start countdown
- Prog_Sync  in  1  synchronized, one-cycle programming strobe
- Time_Param_Sel  in  2  parameter to program: 0 base, 1 ext, 2 yel, 3 walk
- Time_Value  in  4  new value in seconds
- expired  out  1  one-cycle pulse: selected interval elapsed
- busy  out  1  countdown active
- seconds_left  out  4  remaining whole seconds; 0 when idle
- one_hz_enable  out  1  free-running one-cycle pulse every TICKS_PER_SEC cycles

Behaviour:
- Reset (async, active-high): param regs to *_DEF, state IDLE, prescaler 0, expired=0, busy=0, seconds_left=0, one_hz_enable=0.
- Free-running divider (independent of countdown):
  - 0..TICKS_PER_SEC-1.
  - one_hz_enable registered, high for the cycle after the divider wraps.
- Parameter write:
  - On Prog_Sync, reg[Time_Param_Sel] <= Time_Value.
  - Time_Value==0 stores that slot's *_DEF instead. Zero intervals are never held.
- Interval lookup, sampled on the start_timer cycle:
  - codes 0-3 select the matching reg;
  - codes 4-7 load 1 second.
- State machine, two states (IDLE, COUNT):
  - IDLE --start_timer--> COUNT: seconds_left <= lookup value, countdown prescaler <= 0, busy <= 1.
  - In COUNT, the countdown prescaler increments each cycle. The countdown has its own prescaler, separate from the free-running divider, so start is phase-aligned.
  - At TICKS_PER_SEC-1 the prescaler wraps to 0 and seconds_left decrements.
  - If seconds_left==1 at that wrap: expired <= 1 for one cycle, seconds_left <= 0, busy <= 0, state IDLE.
- Latency: start_timer sampled at edge k gives expired high during the cycle after edge k + N*TICKS_PER_SEC, where N = loaded value.
- start_timer while COUNT: restart. Reload from the current interval, prescaler to 0, no expired pulse for the aborted count.
- start_timer in the same cycle as the final wrap: expired still pulses, and the new countdown loads (state stays COUNT, busy stays 1).
- Prog_Sync while COUNT: aborts the countdown to IDLE (busy=0, seconds_left=0, no expired) and performs the write.
- Prog_Sync and start_timer in the same cycle: Prog_Sync wins; start_timer is ignored; state IDLE.
- expired is never high for more than one consecutive cycle. It is never high in IDLE unless a count just finished.
- seconds_left saturates; it never underflows below 0.

Test Plan:
- TICKS_PER_SEC=4; reset, then start_timer with interval=0 -> expired pulses exactly 24 cycles after the start edge, busy high for those 24 cycles, seconds_left steps 6,5,...,1,0.
- Prog_Sync with Time_Param_Sel=2, Time_Value=5, then start with interval=2 -> expired after 20 cycles. Repeat with Time_Value=0 -> reg reads default, expired after 8 cycles.
- Start interval=1 (3 s); at cycle 6 re-pulse start_timer with interval=2 -> no expired at cycle 12; single expired at cycle 6+8=14.
- Start interval=3; Prog_Sync at cycle 5 -> busy drops next cycle, no expired. Prog_Sync and start_timer together -> stays IDLE, register written.
- Assert Reset mid-count at cycle 7 -> all outputs 0 immediately (asynchronous), params back to defaults; after release, interval=5 (reserved) -> expired after 4 cycles.
- Start timed to coincide with the final wrap -> one expired pulse, busy remains 1, new count runs full length; one_hz_enable pulses every 4 cycles throughout.
